// File: rtl/shift_sub_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, valid/ready
// on both the operand and the result side, with a divide-by-zero shortcut.
module shift_sub_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             dbz_q, dbz_d;

    // The trial value needs one extra bit only for the compare; the difference
    // always fits back into WIDTH bits because it is smaller than the divisor.
    logic [WIDTH:0]   trial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quo_d      = quo_q;
        rem_d      = rem_q;
        dvs_d      = dvs_q;
        dbz_d      = dbz_q;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        trial      = {rem_q, quo_q[WIDTH-1]};

        case (state_q)
            IDLE: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    dvs_d = divisor;
                    if (divisor != '0) begin
                        quo_d   = dividend;
                        rem_d   = '0;
                        cnt_d   = CNT_LAST;
                        dbz_d   = 1'b0;
                        state_d = CALC;
                    end else begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                if (trial >= {1'b0, dvs_q}) begin
                    rem_d = trial[WIDTH-1:0] - dvs_q;
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            DONE: begin
                dout_valid = 1'b1;
                if (dout_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Scoreboard bench for shift_sub_divider: stimulus pushes reference results,
// an independent monitor pops and compares on every result handshake.
module tb_shift_sub_divider;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         dout_valid;
    logic         dout_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pushed = 0;
    int   popped = 0;
    int   dropped = 0;
    int   cyc = 0;
    int   acceptBase = 0;
    bit   stopRand = 1'b0;

    shift_sub_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Plain arithmetic reference: division by zero yields all-ones and the dividend.
    function automatic res_t refModel(input int unsigned a, input int unsigned b);
        res_t r;
        if (b == 0) begin
            r.q = W'((1 << W) - 1);
            r.r = W'(a);
            r.z = 1'b1;
        end else begin
            r.q = W'(a / b);
            r.r = W'(a % b);
            r.z = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] randOp();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        bit accepted = 1'b0;
        dividend  = a;
        divisor   = b;
        din_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (din_ready) begin
                sb.push_back(refModel(a, b));
                pushed++;
                acceptBase = cyc;
                accepted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: din_ready stayed %0b, expected 1", din_ready);
        end
        @(negedge clk);
        din_valid = 1'b0;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
    endtask

    task automatic waitDrain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: %0d results pending, expected 0", sb.size());
            dropped += sb.size();
            sb.delete();
        end
    endtask

    task automatic waitValid(input int limit, output int lat, output bit busyOk);
        busyOk = 1'b1;
        for (int i = 0; i < limit; i++) begin
            if (dout_valid) break;
            if (din_ready) busyOk = 1'b0;
            @(negedge clk);
        end
        lat = cyc - acceptBase;
    endtask

    initial begin : monitor
        res_t exp;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n && dout_valid && dout_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got q=%0d r=%0d, expected none", quotient, remainder);
                end else begin
                    exp = sb.pop_front();
                    popped++;
                    checkOutput("quotient", quotient, exp.q);
                    checkOutput("remainder", remainder, exp.r);
                    checkOutput("div_by_zero", div_by_zero, exp.z);
                end
            end
        end
    end

    initial begin : mainSeq
        int lat;
        bit busyOk;

        @(negedge clk);
        checkOutput("reset_din_ready", din_ready, 1);
        checkOutput("reset_dout_valid", dout_valid, 0);
        checkOutput("reset_quotient", quotient, 0);
        checkOutput("reset_remainder", remainder, 0);
        checkOutput("reset_dbz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Latency counts the accept edge itself as the first edge.
        dout_ready = 1'b1;
        applyStimulus(8'd100, 8'd7);
        waitValid(50, lat, busyOk);
        checkOutput("latency_100_7", lat, 9);
        checkOutput("busy_100_7", busyOk, 1);
        @(negedge clk);
        checkOutput("ready_after_100_7", din_ready, 1);

        applyStimulus(8'd255, 8'd1);
        applyStimulus(8'd5, 8'd9);
        waitDrain(100);

        applyStimulus(8'd37, 8'd0);
        waitValid(50, lat, busyOk);
        checkOutput("latency_dbz", lat, 1);
        applyStimulus(8'd0, 8'd3);
        waitDrain(100);

        // Result must hold while downstream stalls, and new operands are ignored.
        dout_ready = 1'b0;
        applyStimulus(8'd200, 8'd13);
        din_valid = 1'b1;
        dividend  = 8'd1;
        divisor   = 8'd1;
        waitValid(50, lat, busyOk);
        checkOutput("busy_200_13", busyOk, 1);
        for (int i = 0; i < 6; i++) begin
            checkOutput("hold_valid", dout_valid, 1);
            checkOutput("hold_quotient", quotient, 15);
            checkOutput("hold_remainder", remainder, 5);
            checkOutput("hold_din_ready", din_ready, 0);
            @(negedge clk);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);
        checkOutput("idle_after_release", din_ready, 1);
        checkOutput("valid_after_release", dout_valid, 0);
        checkOutput("kept_quotient", quotient, 15);
        checkOutput("kept_remainder", remainder, 5);
        waitDrain(10);

        // Reset in the middle of CALC discards the operation.
        applyStimulus(8'd99, 8'd4);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_din_ready", din_ready, 1);
        checkOutput("midreset_dout_valid", dout_valid, 0);
        checkOutput("midreset_quotient", quotient, 0);
        checkOutput("midreset_remainder", remainder, 0);
        checkOutput("midreset_dbz", div_by_zero, 0);
        dropped += sb.size();
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(8'd99, 8'd4);
        waitDrain(100);

        fork
            begin
                for (int i = 0; i < 2000; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    applyStimulus(randOp(), randOp());
                end
                waitDrain(2000);
                stopRand = 1'b1;
            end
            begin
                while (!stopRand) begin
                    dout_ready = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                end
            end
        join

        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", sb.size(), 0);
        checkOutput("result_count", popped, pushed - dropped);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
